// File: rtl/sprite_mover.sv
// Multi-channel vertical sprite mover: per-channel step timers drive wrapping y
// positions, with a registered per-pixel coverage test against the current positions.
module sprite_mover #(
    parameter int N_SPR    = 2,
    parameter int SCREEN_H = 480,
    parameter int SPR_H    = 40,
    parameter int SPR_W    = 40,
    parameter int INIT_Y   = 400,
    localparam int IDX_W   = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_SPR-1:0]      dir,
    input  logic [N_SPR*32-1:0]   period,
    input  logic [N_SPR*10-1:0]   x_left,
    input  logic                  ld,
    input  logic [IDX_W-1:0]      ld_idx,
    input  logic [9:0]            ld_y,
    input  logic [9:0]            px_x,
    input  logic [9:0]            px_y,
    output logic [N_SPR*10-1:0]   y_top,
    output logic [N_SPR-1:0]      wrap,
    output logic [N_SPR-1:0]      hit,
    output logic                  any_hit,
    output logic [IDX_W-1:0]      hit_idx
);

    localparam logic [9:0]  Y_MAX  = 10'(SCREEN_H - SPR_H);
    localparam logic [9:0]  Y_INIT = 10'(INIT_Y);
    localparam logic [10:0] W_EXT  = 11'(SPR_W);
    localparam logic [10:0] H_EXT  = 11'(SPR_H);

    logic [31:0]      cnt_q [N_SPR];
    logic [31:0]      cnt_d [N_SPR];
    logic [9:0]       y_q   [N_SPR];
    logic [9:0]       y_d   [N_SPR];
    logic [N_SPR-1:0] wrap_q, wrap_d;
    logic [N_SPR-1:0] hit_q, hit_d;
    logic             any_hit_q, any_hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic [N_SPR-1:0] step;

    // A load wins over a coincident step on its own channel only.
    always_comb begin
        for (int i = 0; i < N_SPR; i++) begin
            cnt_d[i]  = cnt_q[i];
            y_d[i]    = y_q[i];
            wrap_d[i] = 1'b0;
            step[i]   = en && (cnt_q[i] >= period[32*i +: 32]);
            if (ld && (ld_idx == IDX_W'(i))) begin
                y_d[i]   = (ld_y > Y_MAX) ? Y_MAX : ld_y;
                cnt_d[i] = '0;
            end else begin
                if (en) begin
                    cnt_d[i] = step[i] ? 32'd0 : cnt_q[i] + 32'd1;
                end
                if (step[i]) begin
                    if (!dir[i]) begin
                        if (y_q[i] == Y_MAX) begin
                            y_d[i]    = '0;
                            wrap_d[i] = 1'b1;
                        end else begin
                            y_d[i] = y_q[i] + 10'd1;
                        end
                    end else begin
                        if (y_q[i] == '0) begin
                            y_d[i]    = Y_MAX;
                            wrap_d[i] = 1'b1;
                        end else begin
                            y_d[i] = y_q[i] - 10'd1;
                        end
                    end
                end
            end
        end
    end

    // Coverage uses 11-bit sums so x_left/y_top near 1023 do not wrap.
    always_comb begin
        hit_d     = '0;
        hit_idx_d = '0;
        for (int i = 0; i < N_SPR; i++) begin
            hit_d[i] = ({1'b0, px_x} > {1'b0, x_left[10*i +: 10]}) &&
                       ({1'b0, px_x} < ({1'b0, x_left[10*i +: 10]} + W_EXT)) &&
                       ({1'b0, px_y} > {1'b0, y_q[i]}) &&
                       ({1'b0, px_y} < ({1'b0, y_q[i]} + H_EXT));
        end
        any_hit_d = |hit_d;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_d[i]) begin
                hit_idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SPR; i++) begin
                cnt_q[i] <= '0;
                y_q[i]   <= Y_INIT;
            end
            wrap_q    <= '0;
            hit_q     <= '0;
            any_hit_q <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                cnt_q[i] <= cnt_d[i];
                y_q[i]   <= y_d[i];
            end
            wrap_q    <= wrap_d;
            hit_q     <= hit_d;
            any_hit_q <= any_hit_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    always_comb begin
        y_top = '0;
        for (int i = 0; i < N_SPR; i++) begin
            y_top[10*i +: 10] = y_q[i];
        end
    end

    assign wrap    = wrap_q;
    assign hit     = hit_q;
    assign any_hit = any_hit_q;
    assign hit_idx = hit_idx_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover (two channels) against a plain-arithmetic
// reference model of positions, step timers and pixel coverage.
module tb_sprite_mover;

    localparam int YMAX = 440;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [1:0]  dir = '0;
    logic [63:0] period = '0;
    logic [19:0] x_left = '0;
    logic        ld = 1'b0;
    logic        ld_idx = 1'b0;
    logic [9:0]  ld_y = '0;
    logic [9:0]  px_x = '0;
    logic [9:0]  px_y = '0;
    logic [19:0] y_top;
    logic [1:0]  wrap;
    logic [1:0]  hit;
    logic        any_hit;
    logic        hit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    longint m_cnt [2];
    int     m_y   [2];
    bit     m_wrap[2];
    bit     m_hit [2];
    bit     m_any;
    int     m_idx;

    sprite_mover #(.N_SPR(2), .SCREEN_H(480), .SPR_H(40), .SPR_W(40), .INIT_Y(400)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .period(period), .x_left(x_left),
        .ld(ld), .ld_idx(ld_idx), .ld_y(ld_y), .px_x(px_x), .px_y(px_y),
        .y_top(y_top), .wrap(wrap), .hit(hit), .any_hit(any_hit), .hit_idx(hit_idx)
    );

    always #10 clk = ~clk;

    function automatic void model_step();
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_y[i] = 400; m_wrap[i] = 0; m_hit[i] = 0;
            end
            m_any = 0; m_idx = 0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            int xl;
            xl = int'(x_left[10*i +: 10]);
            m_hit[i] = (int'(px_x) > xl) && (int'(px_x) < xl + 40) &&
                       (int'(px_y) > m_y[i]) && (int'(px_y) < m_y[i] + 40);
        end
        m_any = m_hit[0] || m_hit[1];
        m_idx = m_hit[0] ? 0 : (m_hit[1] ? 1 : 0);
        for (int i = 0; i < 2; i++) begin
            longint p;
            bit     stp;
            p   = longint'(period[32*i +: 32]);
            stp = en && (m_cnt[i] >= p);
            m_wrap[i] = 0;
            if (ld && int'(ld_idx) == i) begin
                m_y[i]   = (int'(ld_y) > YMAX) ? YMAX : int'(ld_y);
                m_cnt[i] = 0;
            end else begin
                if (en) m_cnt[i] = stp ? 0 : m_cnt[i] + 1;
                if (stp) begin
                    if (!dir[i]) begin
                        m_y[i]    = (m_y[i] + 1) % (YMAX + 1);
                        m_wrap[i] = (m_y[i] == 0);
                    end else begin
                        m_wrap[i] = (m_y[i] == 0);
                        m_y[i]    = (m_y[i] + YMAX) % (YMAX + 1);
                    end
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (y_top !== {10'd400, 10'd400}) begin n_fail++; $display("FAIL reset_y_top: got %h expected %h", y_top, {10'd400, 10'd400}); end
        n_checks++; if (wrap !== 2'b00) begin n_fail++; $display("FAIL reset_wrap: got %b expected 00", wrap); end
        n_checks++; if ({hit, any_hit, hit_idx} !== 4'b0) begin n_fail++; $display("FAIL reset_hit: got %b expected 0000", {hit, any_hit, hit_idx}); end
    endtask

    task automatic test_wrap_down();
        period = {32'hFFFF_FFFF, 32'd0};
        dir    = 2'b00;
        en     = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_checks++; if (int'(y_top[9:0]) != 400 + k) begin n_fail++; $display("FAIL down_step_%0d: got %0d expected %0d", k, y_top[9:0], 400 + k); end
        end
        tick();
        n_checks++; if (y_top[9:0] !== 10'd0 || wrap[0] !== 1'b1) begin n_fail++; $display("FAIL down_wrap: got y=%0d wrap=%b expected y=0 wrap=1", y_top[9:0], wrap[0]); end
        tick();
        n_checks++; if (y_top[9:0] !== 10'd1 || wrap[0] !== 1'b0) begin n_fail++; $display("FAIL down_wrap_pulse: got y=%0d wrap=%b expected y=1 wrap=0", y_top[9:0], wrap[0]); end
    endtask

    task automatic test_up_wrap_hold();
        period = {32'd4, 32'd1000};
        dir    = 2'b10;
        ld = 1'b1; ld_idx = 1'b1; ld_y = 10'd0;
        tick();
        ld = 1'b0;
        n_checks++; if (y_top[19:10] !== 10'd0) begin n_fail++; $display("FAIL up_load: got %0d expected 0", y_top[19:10]); end
        repeat (4) tick();
        n_checks++; if (y_top[19:10] !== 10'd0 || wrap[1] !== 1'b0) begin n_fail++; $display("FAIL up_early: got y=%0d wrap=%b expected y=0 wrap=0", y_top[19:10], wrap[1]); end
        tick();
        n_checks++; if (y_top[19:10] !== 10'd440 || wrap[1] !== 1'b1) begin n_fail++; $display("FAIL up_wrap: got y=%0d wrap=%b expected y=440 wrap=1", y_top[19:10], wrap[1]); end
        ld = 1'b1; ld_idx = 1'b1; ld_y = 10'd100;
        tick();
        ld = 1'b0;
        repeat (2) tick();
        en = 1'b0;
        repeat (3) tick();
        n_checks++; if (y_top[19:10] !== 10'd100) begin n_fail++; $display("FAIL en_hold: got %0d expected 100", y_top[19:10]); end
        en = 1'b1;
        repeat (2) tick();
        n_checks++; if (y_top[19:10] !== 10'd100) begin n_fail++; $display("FAIL en_resume_early: got %0d expected 100", y_top[19:10]); end
        tick();
        n_checks++; if (y_top[19:10] !== 10'd99) begin n_fail++; $display("FAIL en_resume_step: got %0d expected 99", y_top[19:10]); end
    endtask

    task automatic test_load();
        ld = 1'b1; ld_idx = 1'b0; ld_y = 10'd470;
        tick();
        n_checks++; if (y_top[9:0] !== 10'd440) begin n_fail++; $display("FAIL load_clamp: got %0d expected 440", y_top[9:0]); end
        period[31:0] = 32'd0;
        dir[0] = 1'b0;
        en = 1'b1;
        ld_y = 10'd440;
        tick();
        ld = 1'b0;
        n_checks++; if (y_top[9:0] !== 10'd440 || wrap[0] !== 1'b0) begin n_fail++; $display("FAIL load_over_step: got y=%0d wrap=%b expected y=440 wrap=0", y_top[9:0], wrap[0]); end
        n_checks++; if (int'(y_top[19:10]) != m_y[1] || wrap[1] !== m_wrap[1]) begin n_fail++; $display("FAIL load_other_ch: got y=%0d wrap=%b expected y=%0d wrap=%b", y_top[19:10], wrap[1], m_y[1], m_wrap[1]); end
        tick();
        n_checks++; if (y_top[9:0] !== 10'd0 || wrap[0] !== 1'b1) begin n_fail++; $display("FAIL load_then_step: got y=%0d wrap=%b expected y=0 wrap=1", y_top[9:0], wrap[0]); end
    endtask

    task automatic test_hit();
        int tx[6]  = '{301, 300, 340, 339, 301, 301};
        int ty[6]  = '{401, 401, 401, 439, 440, 400};
        bit te[6]  = '{1,   0,   0,   1,   0,   0};
        en = 1'b0;
        ld = 1'b1; ld_idx = 1'b0; ld_y = 10'd400;
        tick();
        ld_idx = 1'b1; ld_y = 10'd0;
        tick();
        ld = 1'b0;
        x_left = {10'd600, 10'd300};
        for (int k = 0; k < 6; k++) begin
            px_x = 10'(tx[k]); px_y = 10'(ty[k]);
            tick();
            n_checks++; if (hit[0] !== te[k]) begin n_fail++; $display("FAIL hit_case_%0d (%0d,%0d): got %b expected %b", k, tx[k], ty[k], hit[0], te[k]); end
            n_checks++; if (hit !== {m_hit[1], m_hit[0]}) begin n_fail++; $display("FAIL hit_model_%0d: got %b expected %b", k, hit, {m_hit[1], m_hit[0]}); end
        end
        x_left[9:0] = 10'd1000;
        px_x = 10'd1020; px_y = 10'd420;
        tick();
        n_checks++; if (hit[0] !== 1'b1) begin n_fail++; $display("FAIL hit_wide_x: got %b expected 1", hit[0]); end
    endtask

    task automatic test_any_hit_period();
        en = 1'b0;
        x_left = {10'd300, 10'd300};
        ld = 1'b1; ld_idx = 1'b0; ld_y = 10'd400;
        tick();
        ld_idx = 1'b1;
        tick();
        ld = 1'b0;
        px_x = 10'd320; px_y = 10'd420;
        tick();
        n_checks++; if ({hit, any_hit, hit_idx} !== 4'b1110) begin n_fail++; $display("FAIL any_hit_both: got %b expected 1110", {hit, any_hit, hit_idx}); end
        x_left[9:0] = 10'd0;
        tick();
        n_checks++; if ({hit, any_hit, hit_idx} !== 4'b1011) begin n_fail++; $display("FAIL any_hit_ch1: got %b expected 1011", {hit, any_hit, hit_idx}); end
        px_x = 10'd0; px_y = 10'd0;
        tick();
        n_checks++; if ({any_hit, hit_idx} !== 2'b00) begin n_fail++; $display("FAIL any_hit_none: got %b expected 00", {any_hit, hit_idx}); end
        en = 1'b1;
        dir[0] = 1'b0;
        period[31:0] = 32'd100;
        ld = 1'b1; ld_idx = 1'b0; ld_y = 10'd0;
        tick();
        ld = 1'b0;
        repeat (50) tick();
        n_checks++; if (y_top[9:0] !== 10'd0) begin n_fail++; $display("FAIL period_wait: got %0d expected 0", y_top[9:0]); end
        period[31:0] = 32'd3;
        tick();
        n_checks++; if (y_top[9:0] !== 10'd1) begin n_fail++; $display("FAIL period_lowered: got %0d expected 1", y_top[9:0]); end
    endtask

    task automatic test_reset_priority();
        period = 64'd0;
        en = 1'b1;
        x_left = {10'd300, 10'd300};
        px_x = 10'd320; px_y = 10'd420;
        ld = 1'b1; ld_idx = 1'b0; ld_y = 10'd10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ld = 1'b0;
        n_checks++; if (y_top !== {10'd400, 10'd400}) begin n_fail++; $display("FAIL rst_prio_y: got %h expected %h", y_top, {10'd400, 10'd400}); end
        n_checks++; if ({wrap, hit, any_hit} !== 5'b0) begin n_fail++; $display("FAIL rst_prio_flags: got %b expected 00000", {wrap, hit, any_hit}); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) period = {32'($urandom_range(0, 6)), 32'($urandom_range(0, 6))};
            if ($urandom_range(0, 31) == 0) x_left = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
            ld     = ($urandom_range(0, 9) == 0);
            ld_idx = 1'($urandom_range(0, 1));
            ld_y   = 10'($urandom_range(0, 1023));
            begin
                int s;
                s = $urandom_range(0, 1);
                px_x = 10'(int'(x_left[10*s +: 10]) + $urandom_range(0, 41));
                px_y = 10'(m_y[s] + $urandom_range(0, 41));
            end
            tick();
            n_checks++; if (y_top !== {10'(m_y[1]), 10'(m_y[0])}) begin n_fail++; $display("FAIL rnd_y_top@%0d: got %h expected %h", k, y_top, {10'(m_y[1]), 10'(m_y[0])}); end
            n_checks++; if (wrap !== {m_wrap[1], m_wrap[0]}) begin n_fail++; $display("FAIL rnd_wrap@%0d: got %b expected %b", k, wrap, {m_wrap[1], m_wrap[0]}); end
            n_checks++; if (hit !== {m_hit[1], m_hit[0]}) begin n_fail++; $display("FAIL rnd_hit@%0d: got %b expected %b", k, hit, {m_hit[1], m_hit[0]}); end
            n_checks++; if (any_hit !== m_any || hit_idx !== 1'(m_idx)) begin n_fail++; $display("FAIL rnd_any@%0d: got any=%b idx=%0d expected any=%b idx=%0d", k, any_hit, hit_idx, m_any, m_idx); end
        end
        ld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_down();
        test_up_wrap_hold();
        test_load();
        test_hit();
        test_any_hit_period();
        test_reset_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameter N_SPR, default 2, number of independent sprite channels (1..8).
REQ-002 Parameter SCREEN_H, default 480, visible lines; SPR_H, default 40, sprite height; SPR_W, default 40, sprite width.
REQ-003 Parameter INIT_Y, default 400, y_top of every channel after reset; legal range 0..SCREEN_H-SPR_H.
REQ-004 clk  in  1  system clock (50 MHz); the only clock, all state on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  global run enable; 0 freezes all step counters and positions.
REQ-007 dir  in  N_SPR  per-channel direction; 0 = down (+1), 1 = up (-1).
REQ-008 period  in  N_SPR*32  per-channel step period in clk cycles minus one; channel i at bits [32i+31:32i].
REQ-009 x_left  in  N_SPR*10  per-channel left x coordinate.
REQ-010 ld, ld_idx, ld_y  in  1 / clog2(N_SPR) / 10  single-cycle position load request.
REQ-011 px_x, px_y  in  10 each  current pixel coordinate from VGA timing.
REQ-012 y_top  out  N_SPR*10  registered per-channel top coordinate.
REQ-013 wrap  out  N_SPR  one-cycle pulse per channel on wrap-around.
REQ-014 hit  out  N_SPR  registered per-channel pixel coverage; any_hit out 1; hit_idx out clog2(N_SPR).

Function
REQ-015 Each channel SHALL keep a 32-bit step counter cnt; with en=1, cnt>=period -> cnt<=0 and step asserted; else cnt<=cnt+1.
REQ-016 The >= comparison SHALL make a period reduced below current cnt step on the next enabled cycle, never wait for 32-bit wrap.
REQ-017 period=0 SHALL step every enabled cycle.
REQ-018 No derived clocks; step is a clk-domain enable only.
REQ-019 Down step: y_top==SCREEN_H-SPR_H -> y_top<=0 and wrap[i]=1 next cycle; else y_top+1.
REQ-020 Up step: y_top==0 -> y_top<=SCREEN_H-SPR_H and wrap[i]=1; else y_top-1.
REQ-021 wrap[i] SHALL be high exactly one cycle per wrap event, else 0.
REQ-022 ld=1 SHALL set y_top[ld_idx]<=min(ld_y, SCREEN_H-SPR_H) and cnt[ld_idx]<=0, regardless of en.
REQ-023 ld SHALL override a coincident step on that channel (no step, no wrap); other channels unaffected.
REQ-024 ld_idx>=N_SPR SHALL be ignored.
REQ-025 hit[i] SHALL be registered (latency 1) as px_x>x_left[i] AND px_x<x_left[i]+SPR_W AND px_y>y_top[i] AND px_y<y_top[i]+SPR_H, strict both ends.
REQ-026 Sums SHALL be 11 bits wide; no truncation at x_left near 1023.
REQ-027 hit SHALL use y_top as registered on the same edge as px sampling (pre-update value).
REQ-028 any_hit = OR of hit; hit_idx = lowest index with hit set, 0 when any_hit=0; both registered together with hit.
REQ-029 dir changes SHALL take effect on the next step; cnt unaffected.

Reset
REQ-030 rst=1 SHALL set every y_top=INIT_Y, cnt=0, wrap=0, hit=0, any_hit=0, hit_idx=0 on the next edge.
REQ-031 rst SHALL take priority over ld, en and step in the same cycle; reset mid-period discards progress.

Verification
REQ-032 N_SPR=2, period0=0, dir=0, en=1 from reset -> y_top0 reaches 440 after 40 cycles, then 0 with wrap[0] one-cycle pulse.
REQ-033 period1=4, dir1=1, ld ch1 y=0 -> after 5 enabled cycles y_top1=440, wrap[1]=1; en=0 mid-count holds cnt and y_top.
REQ-034 ld ld_idx=0 ld_y=470 -> y_top0=440; ld coincident with step on ch0 -> no step, no wrap.
REQ-035 x_left0=300, y_top0=400: px=(301,401) -> hit0=1 one cycle later; px=(300,401),(340,401),(301,440) -> hit0=0.
REQ-036 Both channels covering same pixel -> any_hit=1, hit_idx=0; period lowered from 100 to 3 at cnt=50 -> step next cycle.
REQ-037 rst asserted with ld and step pending -> all y_top=400, wrap=0, hit=0 next cycle.
